// File: rtl/fetch_if.sv
// Signal bundle between the fetch stage, instruction memory and decode.
// master is the fetch unit's view; slave is the environment's view.
interface fetch_if;
    logic        stall;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_rdy;
    logic [15:0] imem_data;
    logic [15:0] instr_out;
    logic [15:0] pc_next_out;
    logic        instr_valid;

    modport master (
        input  stall, redirect, redirect_pc, imem_rdy, imem_data,
        output imem_req, imem_addr, instr_out, pc_next_out, instr_valid
    );

    modport slave (
        output stall, redirect, redirect_pc, imem_rdy, imem_data,
        input  imem_req, imem_addr, instr_out, pc_next_out, instr_valid
    );
endinterface

// File: rtl/fetch_unit.sv
// Single-issue instruction fetch stage: PC sequencing, bubbles, redirect
// flush and halt detection, with a registered instruction/PC+2 to decode.
module fetch_unit #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic    clk,
    input  logic    rst,
    fetch_if.master bus
);

    localparam logic [0:0] ST_FETCH  = 1'b0;
    localparam logic [0:0] ST_HALTED = 1'b1;

    localparam logic [15:0] NOP_INSTR = 16'h0800;

    logic [0:0]  state_q,  state_d;
    logic [15:0] pc_q,     pc_d;
    logic [15:0] instr_q,  instr_d;
    logic [15:0] pcn_q,    pcn_d;
    logic        valid_q,  valid_d;
    logic [15:0] pc_plus2_s;
    logic        is_halt_s;

    assign pc_plus2_s = pc_q + 16'd2;
    assign is_halt_s  = (bus.imem_data[15:11] == 5'b00000);

    // The request is combinational so a stall or redirect withdraws it in the same cycle.
    assign bus.imem_req    = (state_q == ST_FETCH) && !bus.stall && !bus.redirect && !rst;
    assign bus.imem_addr   = pc_q;
    assign bus.instr_out   = instr_q;
    assign bus.pc_next_out = pcn_q;
    assign bus.instr_valid = valid_q;

    // Next-state selection: redirect beats stall, stall beats normal fetch.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        pcn_d   = pcn_q;
        valid_d = valid_q;
        if (bus.redirect) begin
            state_d = ST_FETCH;
            pc_d    = {bus.redirect_pc[15:1], 1'b0};
            instr_d = NOP_INSTR;
            pcn_d   = 16'h0000;
            valid_d = 1'b0;
        end else if (bus.stall) begin
            state_d = state_q;
        end else begin
            case (state_q)
                ST_FETCH: begin
                    if (bus.imem_rdy) begin
                        instr_d = bus.imem_data;
                        pcn_d   = pc_plus2_s;
                        valid_d = 1'b1;
                        pc_d    = pc_plus2_s;
                        // A halt word is still delivered; fetching stops after it.
                        if (is_halt_s) begin
                            state_d = ST_HALTED;
                        end else begin
                            state_d = ST_FETCH;
                        end
                    end else begin
                        instr_d = NOP_INSTR;
                        valid_d = 1'b0;
                    end
                end
                ST_HALTED: begin
                    instr_d = NOP_INSTR;
                    valid_d = 1'b0;
                end
                default: begin
                    state_d = ST_FETCH;
                    instr_d = NOP_INSTR;
                    valid_d = 1'b0;
                end
            endcase
        end
    end

    // State registers with synchronous reset that overrides every other input.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_FETCH;
            pc_q    <= RESET_PC;
            instr_q <= NOP_INSTR;
            pcn_q   <= 16'h0000;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            pcn_q   <= pcn_d;
            valid_q <= valid_d;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed plus randomized bench for fetch_unit against a behavioural model.
module tb_fetch_unit;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    fetch_if bus();

    fetch_unit #(.RESET_PC(16'h0000)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model state
    logic [15:0] m_pc;
    logic        m_halted;
    logic [15:0] m_instr;
    logic [15:0] m_pcn;
    logic        m_valid;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic r, input logic st, input logic rd,
                        input logic [15:0] rpc, input logic rdy, input logic [15:0] data);
        logic exp_req;
        rst             = r;
        bus.stall       = st;
        bus.redirect    = rd;
        bus.redirect_pc = rpc;
        bus.imem_rdy    = rdy;
        bus.imem_data   = data;
        #3;
        exp_req = !r && !rd && !st && !m_halted;
        check("imem_req", {15'd0, bus.imem_req}, {15'd0, exp_req});
        if (!r) check("imem_addr", bus.imem_addr, m_pc);
        @(posedge clk);
        if (r) begin
            m_pc = 16'h0000; m_halted = 1'b0;
            m_instr = 16'h0800; m_pcn = 16'h0000; m_valid = 1'b0;
        end else if (rd) begin
            m_pc = rpc & 16'hFFFE; m_halted = 1'b0;
            m_instr = 16'h0800; m_pcn = 16'h0000; m_valid = 1'b0;
        end else if (st) begin
            m_pc = m_pc;
        end else if (!m_halted && rdy) begin
            m_instr = data;
            m_pcn   = 16'((32'(m_pc) + 32'd2) % 32'd65536);
            m_pc    = m_pcn;
            m_valid = 1'b1;
            if (data < 16'h0800) m_halted = 1'b1;
        end else begin
            m_instr = 16'h0800; m_valid = 1'b0;
        end
        #1;
        check("instr_out", bus.instr_out, m_instr);
        check("pc_next_out", bus.pc_next_out, m_pcn);
        check("instr_valid", {15'd0, bus.instr_valid}, {15'd0, m_valid});
    endtask

    initial begin
        total = 0;
        bad   = 0;
        m_pc = 16'h0000; m_halted = 1'b0;
        m_instr = 16'h0800; m_pcn = 16'h0000; m_valid = 1'b0;

        // Reset, then two back-to-back fetches
        step(1'b1, 1'b1, 1'b1, 16'h5555, 1'b1, 16'h4444);
        check("reset_pc", bus.imem_addr, 16'h0000);
        step(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h4001);
        check("first_instr", bus.instr_out, 16'h4001);
        check("first_pcn", bus.pc_next_out, 16'h0002);
        step(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h4802);
        check("second_pcn", bus.pc_next_out, 16'h0004);

        // Bubbles at 0x0010
        step(1'b0, 1'b0, 1'b1, 16'h0010, 1'b0, 16'h0000);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h1234);
        check("bubble_addr", bus.imem_addr, 16'h0010);
        step(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h4001);

        // Stall holds everything
        for (int i = 0; i < 2; i++) step(1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h9999);
        check("stall_hold", bus.instr_out, 16'h4001);
        step(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h5A5A);

        // Redirect beats stall; odd target cleared
        step(1'b0, 1'b1, 1'b1, 16'h0123, 1'b1, 16'h7777);
        check("redirect_pc", bus.imem_addr, 16'h0122);
        step(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h6000);

        // Halt at 0x0020
        step(1'b0, 1'b0, 1'b1, 16'h0020, 1'b0, 16'h0000);
        step(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h0000);
        check("halt_pcn", bus.pc_next_out, 16'h0022);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h4321);
        step(1'b0, 1'b0, 1'b1, 16'h0100, 1'b0, 16'h0000);
        step(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h4100);

        // PC wrap, then reset out of HALTED
        step(1'b0, 1'b0, 1'b1, 16'hFFFE, 1'b0, 16'h0000);
        step(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h4ABC);
        check("wrap_pcn", bus.pc_next_out, 16'h0000);
        step(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h07FF);
        step(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h4000);
        step(1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h4000);
        check("rst_from_halt", bus.imem_addr, 16'h0000);
        step(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h4000);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            logic [15:0] d;
            d = 16'($urandom);
            if ($urandom_range(0, 15) == 0) d = {5'b00000, d[10:0]};
            step(($urandom_range(0, 49) == 0),
                 ($urandom_range(0, 4) == 0),
                 ($urandom_range(0, 9) == 0),
                 16'($urandom),
                 ($urandom_range(0, 9) < 6),
                 d);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
